// File: rtl/enemy_hit_monitor.sv
// Frame-level game controller: per-frame enemy move strobe, player/enemy overlap
// detection, lives, post-hit invulnerability and game-over tracking.
module enemy_hit_monitor #(
  parameter int unsigned NENE          = 4,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned MOVE_DIV      = 1,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned HACTIVE       = 640,
  parameter int unsigned VACTIVE       = 480
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pixpulse,
  input  logic [9:0]      hcount,
  input  logic [9:0]      vcount,
  input  logic            start,
  input  logic            draw_player,
  input  logic [NENE-1:0] draw_ene,
  output logic            move,
  output logic            hit,
  output logic [NENE-1:0] hit_mask,
  output logic [2:0]      lives,
  output logic            invuln,
  output logic            game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, INVULN, OVER} state_t;

  state_t          state, state_nxt;
  logic [7:0]      fdiv;
  logic [7:0]      icnt;
  logic [NENE-1:0] ovl_mask;
  logic            frame_end;
  logic            visible;
  logic            start_game;
  logic            take_hit;

  assign frame_end = pixpulse && (hcount == '0) && (vcount == 10'(VACTIVE));
  assign visible   = (hcount < 10'(HACTIVE)) && (vcount < 10'(VACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A start request in IDLE/OVER takes priority over a coincident frame_end.
  always_comb begin
    state_nxt  = state;
    start_game = 1'b0;
    take_hit   = 1'b0;
    unique case (state)
      IDLE, OVER: begin
        if (pixpulse && start) begin
          state_nxt  = PLAY;
          start_game = 1'b1;
        end
      end
      PLAY: begin
        if (frame_end && (ovl_mask != '0)) begin
          take_hit  = 1'b1;
          state_nxt = (lives == 3'd1) ? OVER : INVULN;
        end
      end
      INVULN: begin
        if (frame_end && (icnt == '0)) state_nxt = PLAY;
      end
      default: ;
    endcase
  end

  always_comb begin
    invuln    = (state == INVULN);
    game_over = (state == OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move     <= 1'b0;
      hit      <= 1'b0;
      hit_mask <= '0;
      lives    <= 3'(LIVES);
      fdiv     <= '0;
      icnt     <= '0;
      ovl_mask <= '0;
    end else begin
      hit <= take_hit;
      if (pixpulse) begin
        move <= 1'b0;
        if (start_game) begin
          lives    <= 3'(LIVES);
          fdiv     <= '0;
          ovl_mask <= '0;
          hit_mask <= '0;
        end else begin
          if (frame_end) begin
            ovl_mask <= '0;
            if (state == PLAY || state == INVULN) begin
              if (fdiv == 8'(MOVE_DIV - 1)) begin
                fdiv <= '0;
                move <= 1'b1;
              end else begin
                fdiv <= fdiv + 8'd1;
              end
            end
          end else if (visible && draw_player) begin
            ovl_mask <= ovl_mask | draw_ene;
          end
          if (take_hit) begin
            hit_mask <= ovl_mask;
            lives    <= lives - 3'd1;
            icnt     <= 8'(INVULN_FRAMES - 1);
          end else if (state == INVULN && frame_end && icnt != '0) begin
            icnt <= icnt - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_enemy_hit_monitor.sv
// Randomized bench for enemy_hit_monitor using compressed frames (a few pixels
// plus the frame_end pixel) checked against a frame-counting reference model.
module tb_enemy_hit_monitor;

  localparam int NENE          = 4;
  localparam int LIVES         = 3;
  localparam int MOVE_DIV      = 2;
  localparam int INVULN_FRAMES = 3;
  localparam int HACTIVE       = 640;
  localparam int VACTIVE       = 480;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pixpulse = 1'b0;
  logic [9:0]      hcount = '0;
  logic [9:0]      vcount = '0;
  logic            start = 1'b0;
  logic            draw_player = 1'b0;
  logic [NENE-1:0] draw_ene = '0;
  logic            move, hit, invuln, game_over;
  logic [NENE-1:0] hit_mask;
  logic [2:0]      lives;

  int checks = 0;
  int errors = 0;

  enemy_hit_monitor #(
    .NENE(NENE), .LIVES(LIVES), .MOVE_DIV(MOVE_DIV),
    .INVULN_FRAMES(INVULN_FRAMES), .HACTIVE(HACTIVE), .VACTIVE(VACTIVE)
  ) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .start(start), .draw_player(draw_player), .draw_ene(draw_ene),
    .move(move), .hit(hit), .hit_mask(hit_mask), .lives(lives),
    .invuln(invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Reference model: game tracked as frame counts since start and the frame
  // index at which invulnerability expires.
  bit        m_active, m_over;
  int        m_lives, m_frames, m_inv_end, fe_idx;
  logic [3:0] m_mask, e_mask;
  bit        e_hit, e_move;

  task automatic m_reset();
    m_active = 0; m_over = 0; m_lives = LIVES; m_frames = 0;
    m_inv_end = -1; fe_idx = 0; m_mask = '0; e_mask = '0; e_hit = 0; e_move = 0;
  endtask

  task automatic m_pixel(input logic [9:0] h, input logic [9:0] v, input logic dp,
                         input logic [3:0] de, input logic st);
    bit fe;
    fe     = (h == 0) && (v == VACTIVE);
    e_hit  = 0;
    e_move = 0;
    if (st && !m_active) begin
      m_active = 1; m_over = 0; m_lives = LIVES; m_frames = 0;
      m_mask = '0; e_mask = '0; m_inv_end = -1;
    end else if (fe) begin
      if (m_active) begin
        fe_idx++;
        m_frames++;
        e_move = (m_frames % MOVE_DIV) == 0;
        if (fe_idx > m_inv_end && m_mask != '0) begin
          e_hit = 1; e_mask = m_mask; m_lives--;
          m_inv_end = fe_idx + INVULN_FRAMES;
          if (m_lives == 0) begin m_active = 0; m_over = 1; end
        end
      end
      m_mask = '0;
    end else if (h < HACTIVE && v < VACTIVE && dp) begin
      m_mask = m_mask | de;
    end
  endtask

  // Drives one pixel (4 clks, pixpulse on the first) and compares every output.
  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic dp,
                      input logic [3:0] de, input logic st);
    logic s_hit0, s_hit1, e_inv;
    logic [3:0] mv;
    hcount = h; vcount = v; draw_player = dp; draw_ene = de; start = st; pixpulse = 1'b1;
    m_pixel(h, v, dp, de, st);
    e_inv = m_active && (fe_idx < m_inv_end);
    @(negedge clk);
    pixpulse = 1'b0; start = 1'b0;
    s_hit0 = hit; mv[0] = move;
    checks++;
    if (lives !== 3'(m_lives)) begin errors++; $display("FAIL lives t=%0t: got %0d expected %0d", $time, lives, m_lives); end
    checks++;
    if (invuln !== e_inv) begin errors++; $display("FAIL invuln t=%0t: got %b expected %b", $time, invuln, e_inv); end
    checks++;
    if (game_over !== m_over) begin errors++; $display("FAIL game_over t=%0t: got %b expected %b", $time, game_over, m_over); end
    checks++;
    if (hit_mask !== e_mask) begin errors++; $display("FAIL hit_mask t=%0t: got %b expected %b", $time, hit_mask, e_mask); end
    @(negedge clk); s_hit1 = hit; mv[1] = move;
    @(negedge clk); mv[2] = move;
    @(negedge clk); mv[3] = move;
    checks++;
    if (s_hit0 !== e_hit) begin errors++; $display("FAIL hit_pulse t=%0t: got %b expected %b", $time, s_hit0, e_hit); end
    checks++;
    if (s_hit1 !== 1'b0) begin errors++; $display("FAIL hit_width t=%0t: got %b expected 0", $time, s_hit1); end
    checks++;
    if (mv !== {4{e_move}}) begin errors++; $display("FAIL move t=%0t: got %b expected %b", $time, mv, {4{e_move}}); end
  endtask

  // mode 0: no overlap, 1: random, 2: overlap only in blanking, 3: 0101 overlap on visible pixels
  task automatic frame(input int npix, input int mode, input int st_idx);
    for (int i = 0; i < npix; i++) begin
      logic [9:0] h, v;
      logic dp, vis;
      logic [3:0] de;
      vis = (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      if (vis) begin
        h = 10'($urandom_range(0, HACTIVE - 1)); v = 10'($urandom_range(0, VACTIVE - 1));
      end else begin
        case ($urandom_range(0, 2))
          0: begin h = 10'($urandom_range(HACTIVE, 799)); v = 10'($urandom_range(0, 524)); end
          1: begin h = 10'($urandom_range(0, 799)); v = 10'($urandom_range(VACTIVE + 1, 524)); end
          default: begin h = 10'($urandom_range(1, 799)); v = 10'(VACTIVE); end
        endcase
      end
      de = 4'($urandom_range(0, 15));
      case (mode)
        0: begin dp = 1'($urandom_range(0, 1)); if (dp) de = '0; end
        1: dp = 1'($urandom_range(0, 1));
        2: begin dp = !vis; de = de | 4'b0001; end
        default: begin dp = 1'b1; de = 4'b0101; end
      endcase
      step(h, v, dp, de, i == st_idx);
    end
    step(10'd0, 10'(VACTIVE), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), npix == st_idx);
  endtask

  task automatic test_reset();
    checks++;
    if ({move, hit, hit_mask, lives, invuln, game_over} !== {1'b0, 1'b0, 4'b0, 3'(LIVES), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got move=%b hit=%b mask=%b lives=%0d inv=%b over=%b expected 0 0 0000 %0d 0 0",
               move, hit, hit_mask, lives, invuln, game_over, LIVES);
    end
    frame(5, 1, -1);
  endtask

  task automatic test_move();
    frame(4, 0, 0);
    for (int f = 0; f < 4; f++) frame(4, 0, -1);
    checks++;
    if (lives !== 3'd3) begin errors++; $display("FAIL move_lives: got %0d expected 3", lives); end
  endtask

  task automatic test_hit();
    frame(10, 3, -1);
    checks++;
    if ({lives, hit_mask, invuln} !== {3'd2, 4'b0101, 1'b1}) begin
      errors++; $display("FAIL first_hit: got lives=%0d mask=%b inv=%b expected 2 0101 1", lives, hit_mask, invuln);
    end
  endtask

  task automatic test_invuln();
    for (int f = 0; f < 3; f++) frame(3, 3, -1);
    checks++;
    if ({lives, invuln} !== {3'd2, 1'b0}) begin
      errors++; $display("FAIL invuln_expiry: got lives=%0d inv=%b expected 2 0", lives, invuln);
    end
    frame(3, 3, -1);
    checks++;
    if (lives !== 3'd1) begin errors++; $display("FAIL second_hit: got %0d expected 1", lives); end
  endtask

  task automatic test_game_over();
    for (int f = 0; f < 4; f++) frame(3, 3, -1);
    checks++;
    if ({lives, game_over} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL game_over_state: got lives=%0d over=%b expected 0 1", lives, game_over);
    end
    frame(6, 1, -1);
    frame(6, 1, -1);
    frame(4, 0, 0);
    checks++;
    if ({lives, hit_mask, game_over} !== {3'd3, 4'b0, 1'b0}) begin
      errors++; $display("FAIL restart: got lives=%0d mask=%b over=%b expected 3 0000 0", lives, hit_mask, game_over);
    end
  endtask

  task automatic test_blanking();
    for (int f = 0; f < 3; f++) frame(8, 2, -1);
    checks++;
    if (lives !== 3'd3) begin errors++; $display("FAIL blanking_lives: got %0d expected 3", lives); end
  endtask

  task automatic test_start_at_fe();
    rst = 1'b1; @(negedge clk); rst = 1'b0; m_reset();
    frame(3, 0, 3);
    checks++;
    if ({move, game_over, lives} !== {1'b0, 1'b0, 3'd3}) begin
      errors++; $display("FAIL start_at_fe: got move=%b over=%b lives=%0d expected 0 0 3", move, game_over, lives);
    end
    frame(3, 0, -1);
    frame(3, 0, -1);
  endtask

  task automatic test_reset_mid();
    frame(3, 0, -1);
    frame(3, 0, -1);
    while (!e_move) frame(2, 0, -1);
    checks++;
    if (move !== 1'b1) begin errors++; $display("FAIL pre_reset_move: got %b expected 1", move); end
    rst = 1'b1; #1;
    checks++;
    if ({move, lives, invuln, game_over} !== {1'b0, 3'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset_move: got move=%b lives=%0d expected 0 3", move, lives);
    end
    @(negedge clk); rst = 1'b0; m_reset();
    frame(3, 0, 0);
    frame(6, 3, -1);
    for (int i = 0; i < 4; i++) step(10'(i * 7), 10'(i + 20), 1'b1, 4'b1010, 1'b0);
    rst = 1'b1; #1;
    checks++;
    if ({hit, hit_mask, lives, invuln} !== {1'b0, 4'b0, 3'd3, 1'b0}) begin
      errors++; $display("FAIL async_reset_mid: got hit=%b mask=%b lives=%0d inv=%b expected 0 0000 3 0",
                         hit, hit_mask, lives, invuln);
    end
    @(negedge clk); rst = 1'b0; m_reset();
    frame(2, 1, -1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int npix, mode, st_idx;
      npix   = $urandom_range(2, 8);
      mode   = $urandom_range(0, 3);
      st_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, npix) : -1;
      frame(npix, mode, st_idx);
    end
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_move();
    test_hit();
    test_invuln();
    test_game_over();
    test_blanking();
    test_start_at_fe();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_hit_monitor.md
# enemy_hit_monitor

Frame-level game controller between the VGA timing source and the bouncing-enemy blocks. Generates the per-frame `move` strobe that advances every enemy, detects pixel overlap between the player sprite and any enemy `draw_ene` output, and maintains lives, a post-hit invulnerability window and game-over state. Sits downstream of each enemy's `draw_ene` and upstream of each enemy's `move` input.

## Interface
- `NENE`, 4: number of enemy draw inputs.
- `LIVES`, 3: lives loaded at start; 1..7.
- `MOVE_DIV`, 1: frames per move strobe; 1..255.
- `INVULN_FRAMES`, 60: frames of invulnerability after a hit; 1..255.
- `HACTIVE`, 640: visible pixels per line.
- `VACTIVE`, 480: visible lines per frame.

- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `pixpulse` in 1: one-clk enable every 4 clks (25 MHz pixel rate).
- `hcount` in 10: current pixel x.
- `vcount` in 10: current pixel y.
- `start` in 1: level sampled on pixpulse; begins/restarts a game.
- `draw_player` in 1: player sprite covers current pixel.
- `draw_ene` in NENE: bit i set when enemy i covers current pixel.
- `move` out 1: enemy advance strobe, high for exactly one pixpulse interval.
- `hit` out 1: one-clk pulse when a life is lost.
- `hit_mask` out NENE: enemies overlapping the player in the frame of the last hit.
- `lives` out 3: remaining lives.
- `invuln` out 1: high while in INVULN.
- `game_over` out 1: high in OVER.

## Operation
- All state updates only on clk edges where `pixpulse`=1, except `hit` deassertion (next clk).
- frame_end: pixpulse cycle with `hcount`==0 and `vcount`==VACTIVE. Exactly one per frame.
- Overlap capture: on pixpulse with `hcount`<HACTIVE, `vcount`<VACTIVE, `draw_player`=1: `ovl_mask` |= `draw_ene`. Cleared at every frame_end (after use). Multiple overlapping pixels/enemies in one frame count as one hit.
- Frame divider `fdiv` (8 bit): at frame_end in PLAY/INVULN, if `fdiv`==MOVE_DIV-1 then `fdiv`<=0 and `move`<=1, else `fdiv`++. `move`<=0 on every other pixpulse cycle, so it is sampled high by enemies on exactly one pixpulse edge.
- FSM states: IDLE, PLAY, INVULN, OVER.
  - IDLE: `move` held 0. `start`=1 -> PLAY, `lives`<=LIVES, `fdiv`<=0, `ovl_mask`<=0.
  - PLAY: at frame_end with `ovl_mask`!=0: `hit_mask`<=`ovl_mask`, `hit` pulse, `lives`--; new lives==0 -> OVER, else -> INVULN with `icnt`<=INVULN_FRAMES-1.
  - INVULN: overlaps ignored (mask still cleared each frame). At frame_end: `icnt`==0 -> PLAY, else `icnt`--.
  - OVER: `move` held 0, `game_over`=1. `start`=1 -> PLAY exactly as from IDLE (lives reloaded, `hit_mask` cleared).
- `start` in PLAY/INVULN ignored.
- Simultaneous `start` and frame_end in IDLE/OVER: transition to PLAY wins; no move, no hit that frame; `fdiv`=0.
- Hit frame still issues `move` if divider expires (movement independent of hit).

## Timing
- Reset values: `move`=0, `hit`=0, `hit_mask`=0, `lives`=LIVES, `invuln`=0, `game_over`=0, state IDLE, `fdiv`=0, `icnt`=0, `ovl_mask`=0.
- `move`, `lives`, `invuln`, `game_over`, `hit_mask` registered; change on clk after the frame_end pixpulse edge; `move` falls on the next pixpulse edge (4 clks later).
- `hit` high for exactly one clk, the clk after the frame_end edge.
- Collision-to-hit latency: overlap in frame N reported at frame_end of frame N.
- Reset mid-frame: all outputs to reset values immediately; partially captured overlap discarded.

## Test plan
- Reset, `start`=1 one pixpulse, MOVE_DIV=2, no overlap, 5 frames -> `move` pulses at frame_end of frames 2 and 4, each 4 clks wide; `lives`=3.
- PLAY, one frame with `draw_player`=1 and `draw_ene`=4'b0101 on 10 pixels -> single `hit` pulse, `hit_mask`=0101, `lives`=2, `invuln`=1.
- INVULN_FRAMES=3, continuous overlap -> no further hit for 3 frames; `invuln` drops at 4th frame_end; hit on next frame_end, `lives`=1.
- Third hit -> `lives`=0, `game_over`=1, no `move` in later frames; `start` -> PLAY, `lives`=3, `hit_mask`=0.
- Overlap only during blanking (`vcount`=500) -> no hit.
- Assert `rst` mid-frame with overlap captured and `move` high -> outputs reset instantly, IDLE, no hit at next frame_end.
